cache_axi_bridge: RTL and testbench
===================================

CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 SHALL have no parameters.
REQ-002 clk  in  1  clock; all logic posedge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 rd_req  in  1  cache read request.
REQ-005 rd_type  in  3  0 byte, 1 half, 2 word, 4 cache line.
REQ-006 rd_addr  in  32  read address.
REQ-007 rd_rdy  out  1  read request accepted this cycle when rd_req=1.
REQ-008 ret_valid  out  1  one returned read word valid.
REQ-009 ret_last  out  1  final returned word.
REQ-010 ret_data  out  32  returned word.
REQ-011 wr_req  in  1  cache write request.
REQ-012 wr_type  in  3  same encoding as rd_type.
REQ-013 wr_addr  in  32  write address.
REQ-014 wr_wstrb  in  4  byte strobe for non-line writes.
REQ-015 wr_data  in  128  line data; word0 in [31:0].
REQ-016 wr_rdy  out  1  write request accepted this cycle when wr_req=1.
REQ-017 araddr  out  32  AXI read address.
REQ-018 arlen  out  8  beats minus one.
REQ-019 arvalid  out  1  read address valid.
REQ-020 arready  in  1  read address ready.
REQ-021 rdata  in  32  read beat data.
REQ-022 rlast  in  1  last read beat.
REQ-023 rvalid  in  1  read beat valid.
REQ-024 rready  out  1  read beat ready.
REQ-025 awaddr  out  32  write address.
REQ-026 awlen  out  8  beats minus one.
REQ-027 awvalid  out  1  write address valid.
REQ-028 awready  in  1  write address ready.
REQ-029 wdata  out  32  write beat data.
REQ-030 wstrb  out  4  write beat strobe.
REQ-031 wlast  out  1  last write beat.
REQ-032 wvalid  out  1  write beat valid.
REQ-033 wready  in  1  write beat ready.
REQ-034 bvalid  in  1  write response valid.
REQ-035 bready  out  1  write response ready.

Function
REQ-036 SHALL run the read FSM R_IDLE->R_AR on rd_req&&rd_rdy, latching addr and type. R_AR->R_DATA on arvalid&&arready. R_DATA->R_IDLE on rvalid&&rlast. rd_rdy=(R_IDLE && no RAW block); arvalid=(R_AR); rready=(R_DATA).
REQ-037 SHALL drive the read address as follows. Type 4: araddr={addr[31:4],4'h0}, arlen=3. Otherwise: araddr=addr, arlen=0, beats always 4 bytes. Outputs: ret_valid=rvalid&&R_DATA, ret_last=rlast, ret_data=rdata, all combinational, zero latency.
REQ-038 SHALL run the write FSM W_IDLE->W_AW on wr_req&&wr_rdy, latching addr, type, wstrb and data. W_AW->W_DATA on awready. W_DATA->W_B on wvalid&&wready&&wlast. W_B->W_IDLE on bvalid. wr_rdy=(W_IDLE); awvalid=(W_AW); wvalid=(W_DATA); bready=(W_B).
REQ-039 SHALL drive the write beats as follows. Type 4: awaddr={addr[31:4],4'h0}, awlen=3, wstrb=4'hf, wdata=the current word of the latched line. A 2-bit beat counter advances on wvalid&&wready and wraps 3->0. wlast=(count==awlen). Otherwise: awlen=0, wstrb=latched wstrb, wdata=latched data[31:0].
REQ-040 SHALL run the read and write FSMs independently. When rd_req and wr_req are accepted in the same cycle, both SHALL be accepted. Back-to-back requests SHALL be accepted on the cycle the FSM returns to idle. bresp and rresp SHALL be ignored.

Reset
REQ-041 SHALL, while resetn=0, put both FSMs in idle, clear the beat counter, and hold arvalid, awvalid, wvalid, rready, bready, ret_valid and ret_last at 0. rd_rdy and wr_rdy SHALL be 1 on the first cycle after release. Reset mid-burst SHALL abandon the burst without completion.

Configuration
REQ-042 SHALL support macro BRIDGE_RAW_CHECK_EN. Defined: rd_rdy=0 while the write FSM is not in W_IDLE and the latched write addr[31:4] equals rd_addr[31:4]. Undefined: no address compare, and rd_rdy depends only on the read FSM.

Structure
REQ-043 SHALL place the state encodings, TYPE_LINE=3'b100 and LINE_BEATS=4 in package cache_axi_pkg. SHALL have one sub-module, axi_wbeat_buf, holding the 128-bit line and selecting a word by beat count.

Verification
REQ-044 Line read of 0x1C00_0034: araddr=0x1C00_0030, arlen=3; 4 beats with rvalid high -> four ret_valid pulses, ret_last only on the 4th, then rd_rdy=1 the next cycle.
REQ-045 Word write to 0x8000_0008 with wstrb 4'b0110 and data[31:0]=0xDEADBEEF -> one W beat carrying wstrb 0110, wlast=1, data 0xDEADBEEF; wr_rdy=0 until bvalid.
REQ-046 Line write of 0x33..,0x22..,0x11..,0x00.. with wready toggling every cycle -> beats 0x00..,0x11..,0x22..,0x33.. in order, wlast on the 4th, counter back at 0.
REQ-047 Read and write requested in the same cycle to lines 0x100 and 0x200 -> both accepted, both complete.
REQ-048 With BRIDGE_RAW_CHECK_EN: write to 0x40 pending, read of 0x44 held until bvalid. Without the macro: the read is accepted immediately. Reset asserted mid-read -> arvalid and rready are 0 and rd_rdy=1 after release.

Source files
------------

// File: rtl/cache_axi_pkg.sv
// cache_axi_pkg: shared definitions for the cache-to-AXI bridge.
//   rd_state_t / wr_state_t : read and write FSM state encodings
//   TYPE_LINE               : request type code for a full 16-byte cache line
//   LINE_BEATS / LINE_LEN   : beats per line burst and the matching AXI len value
//   line_base()             : aligns an address down to its cache-line base
package cache_axi_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_AR,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_AW,
        W_DATA,
        W_B
    } wr_state_t;

    localparam logic [2:0]  TYPE_LINE  = 3'b100;
    localparam int unsigned LINE_BEATS = 4;
    localparam logic [7:0]  LINE_LEN   = 8'(LINE_BEATS - 1);

    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[31:4], 4'h0};
    endfunction

endpackage

// File: rtl/axi_wbeat_buf.sv
// axi_wbeat_buf: holds the 128-bit write line and presents one 32-bit word.
//   clk, resetn : clock, synchronous active-low reset
//   load        : capture line_in this cycle
//   line_in     : line data, word0 in [31:0]
//   sel         : word index (beat count)
//   word        : selected 32-bit word
module axi_wbeat_buf (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [127:0] line_in,
    input  logic [1:0]   sel,
    output logic [31:0]  word
);

    logic [127:0] line_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= line_in;
        end
    end

    assign word = line_q[{sel, 5'b00000} +: 32];

endmodule

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: converts cache read/write requests into AXI bursts.
//   Cache side : rd_req/rd_type/rd_addr/rd_rdy, ret_valid/ret_last/ret_data,
//                wr_req/wr_type/wr_addr/wr_wstrb/wr_data/wr_rdy
//   AXI read   : araddr/arlen/arvalid/arready, rdata/rlast/rvalid/rready
//   AXI write  : awaddr/awlen/awvalid/awready, wdata/wstrb/wlast/wvalid/wready,
//                bvalid/bready
// Type 4 requests move a full line as a 4-beat burst; other types use a
// single 4-byte beat at the given address.
// Build option: define BRIDGE_RAW_CHECK_EN to stall reads that hit the line
// of a write still in flight.
module cache_axi_bridge
    import cache_axi_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic         arvalid,
    input  logic         arready,
    input  logic [31:0]  rdata,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic         bvalid,
    output logic         bready
);

    rd_state_t   r_state;
    logic [31:0] r_addr;
    logic        r_line;

    wr_state_t   w_state;
    logic [31:0] w_addr;
    logic        w_line;
    logic [3:0]  w_strb;
    logic [1:0]  beat_cnt;
    logic        w_beat;
    logic        raw_block;

    // Read-after-write hazard: hold a read that targets the line being written.
`ifdef BRIDGE_RAW_CHECK_EN
    assign raw_block = (w_state != W_IDLE) && (w_addr[31:4] == rd_addr[31:4]);
`else
    assign raw_block = 1'b0;
`endif

    // Handshakes are qualified with resetn so nothing is presented during reset.
    assign rd_rdy    = resetn && (r_state == R_IDLE) && !raw_block;
    assign arvalid   = resetn && (r_state == R_AR);
    assign rready    = resetn && (r_state == R_DATA);
    assign araddr    = r_line ? line_base(r_addr) : r_addr;
    assign arlen     = r_line ? LINE_LEN : 8'd0;
    assign ret_valid = rvalid && rready;
    assign ret_last  = rlast && resetn;
    assign ret_data  = rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_line  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (rd_req && rd_rdy) begin
                        r_addr  <= rd_addr;
                        r_line  <= (rd_type == TYPE_LINE);
                        r_state <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) r_state <= R_DATA;
                end
                R_DATA: begin
                    if (rvalid && rlast) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign wr_rdy  = resetn && (w_state == W_IDLE);
    assign awvalid = resetn && (w_state == W_AW);
    assign wvalid  = resetn && (w_state == W_DATA);
    assign bready  = resetn && (w_state == W_B);
    assign awaddr  = w_line ? line_base(w_addr) : w_addr;
    assign awlen   = w_line ? LINE_LEN : 8'd0;
    assign wstrb   = w_line ? 4'hf : w_strb;
    assign wlast   = ({6'd0, beat_cnt} == awlen);
    assign w_beat  = wvalid && wready;

    axi_wbeat_buf u_wbeat_buf (
        .clk     (clk),
        .resetn  (resetn),
        .load    (wr_req && wr_rdy),
        .line_in (wr_data),
        .sel     (w_line ? beat_cnt : 2'd0),
        .word    (wdata)
    );

    // The beat counter returns to 0 on the last beat: a line burst wraps 3->0,
    // and a single-beat write leaves it at 0 for the next request.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state  <= W_IDLE;
            w_addr   <= '0;
            w_line   <= 1'b0;
            w_strb   <= '0;
            beat_cnt <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_req && wr_rdy) begin
                        w_addr   <= wr_addr;
                        w_line   <= (wr_type == TYPE_LINE);
                        w_strb   <= wr_wstrb;
                        beat_cnt <= '0;
                        w_state  <= W_AW;
                    end
                end
                W_AW: begin
                    if (awready) w_state <= W_DATA;
                end
                W_DATA: begin
                    if (w_beat) begin
                        if (wlast) begin
                            beat_cnt <= '0;
                            w_state  <= W_B;
                        end else begin
                            beat_cnt <= beat_cnt + 2'd1;
                        end
                    end
                end
                W_B: begin
                    if (bvalid) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge: self-checking bench for cache_axi_bridge.
// A table of directed requests, hand-written corner sequences (concurrent
// read/write, read-after-write hold, reset mid-read) and randomized traffic,
// all checked against expectations derived from the request rules.
module tb_cache_axi_bridge;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         rd_req = 1'b0;
    logic [2:0]   rd_type = '0;
    logic [31:0]  rd_addr = '0;
    logic         rd_rdy;
    logic         ret_valid, ret_last;
    logic [31:0]  ret_data;
    logic         wr_req = 1'b0;
    logic [2:0]   wr_type = '0;
    logic [31:0]  wr_addr = '0;
    logic [3:0]   wr_wstrb = '0;
    logic [127:0] wr_data = '0;
    logic         wr_rdy;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [31:0]  rdata = '0;
    logic         rlast = 1'b0;
    logic         rvalid = 1'b0;
    logic         rready;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic         awvalid;
    logic         awready = 1'b0;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast, wvalid;
    logic         wready = 1'b0;
    logic         bvalid = 1'b0;
    logic         bready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference model: address/length of a request, and slave memory contents.
    function automatic logic [31:0] m_addr(input logic [2:0] t, input logic [31:0] a);
        return (t == 3'd4) ? (a & 32'hFFFF_FFF0) : a;
    endfunction

    function automatic logic [7:0] m_len(input logic [2:0] t);
        return (t == 3'd4) ? 8'd3 : 8'd0;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic do_read(input logic [2:0] t, input logic [31:0] a, input logic [31:0] e_aa,
                           input logic [7:0] e_len, input int agap, input int rgap,
                           output int acc_c);
        int n;
        int nb;
        @(negedge clk);
        rd_req = 1'b1; rd_type = t; rd_addr = a;
        #1;
        n = 0;
        while (!rd_rdy && n < 64) begin
            @(negedge clk); #1; n++;
        end
        chk1("rd_accept", rd_rdy, 1'b1);
        acc_c = cyc;
        @(negedge clk);
        rd_req = 1'b0; rd_type = '0; rd_addr = '0;
        #1;
        repeat (agap) begin
            chk1("arvalid_wait", arvalid, 1'b1);
            @(negedge clk); #1;
        end
        arready = 1'b1;
        #1;
        chk1("arvalid", arvalid, 1'b1);
        chk32("araddr", araddr, e_aa);
        chk32("arlen", 32'(arlen), 32'(e_len));
        @(negedge clk);
        arready = 1'b0;
        #1;
        chk1("arvalid_drop", arvalid, 1'b0);
        chk1("rready", rready, 1'b1);
        nb = int'(e_len) + 1;
        for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(rgap, 0)) begin
                chk1("ret_valid_idle", ret_valid, 1'b0);
                @(negedge clk); #1;
            end
            rvalid = 1'b1;
            rdata  = mem_word(e_aa + 32'(4 * b));
            rlast  = (b == nb - 1);
            #1;
            chk1("ret_valid", ret_valid, 1'b1);
            chk1("ret_last", ret_last, b == nb - 1);
            chk32("ret_data", ret_data, mem_word(e_aa + 32'(4 * b)));
            @(negedge clk);
            rvalid = 1'b0; rlast = 1'b0; rdata = '0;
            #1;
        end
        chk1("rready_done", rready, 1'b0);
        chk1("rd_rdy_after", rd_rdy, 1'b1);
    endtask

    task automatic do_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] strb,
                            input logic [127:0] line, input logic [31:0] e_aa, input logic [7:0] e_len,
                            input int agap, input int wmode, input int bgap,
                            output int acc_c, output int b_c);
        int n;
        int nb;
        int b;
        logic [31:0] e_d;
        @(negedge clk);
        wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = strb; wr_data = line;
        #1;
        n = 0;
        while (!wr_rdy && n < 64) begin
            @(negedge clk); #1; n++;
        end
        chk1("wr_accept", wr_rdy, 1'b1);
        acc_c = cyc;
        @(negedge clk);
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        #1;
        repeat (agap) begin
            chk1("awvalid_wait", awvalid, 1'b1);
            @(negedge clk); #1;
        end
        awready = 1'b1;
        #1;
        chk1("awvalid", awvalid, 1'b1);
        chk1("wr_rdy_busy", wr_rdy, 1'b0);
        chk32("awaddr", awaddr, e_aa);
        chk32("awlen", 32'(awlen), 32'(e_len));
        @(negedge clk);
        awready = 1'b0;
        #1;
        nb = int'(e_len) + 1;
        b = 0;
        n = 0;
        while (b < nb && n < 64) begin
            case (wmode)
                0:       wready = 1'b1;
                1:       wready = (n % 2 == 1);
                default: wready = 1'($urandom_range(1, 0));
            endcase
            #1;
            chk1("wvalid", wvalid, 1'b1);
            if (wready) begin
                e_d = (t == 3'd4) ? line[32 * b +: 32] : line[31:0];
                chk32("wdata", wdata, e_d);
                chk32("wstrb", 32'(wstrb), (t == 3'd4) ? 32'hf : 32'(strb));
                chk1("wlast", wlast, b == nb - 1);
                b++;
            end
            @(negedge clk);
            wready = 1'b0;
            #1;
            n++;
        end
        chk32("w_beats", 32'(b), 32'(nb));
        chk1("wvalid_done", wvalid, 1'b0);
        chk1("bready", bready, 1'b1);
        repeat (bgap) begin
            chk1("wr_rdy_b_wait", wr_rdy, 1'b0);
            @(negedge clk); #1;
        end
        bvalid = 1'b1;
        b_c = cyc;
        @(negedge clk);
        bvalid = 1'b0;
        #1;
        chk1("wr_rdy_after", wr_rdy, 1'b1);
        chk1("bready_done", bready, 1'b0);
    endtask

    typedef struct {
        logic         is_wr;
        logic [2:0]   t;
        logic [31:0]  addr;
        logic [3:0]   strb;
        logic [127:0] line;
        int           wmode;
        logic [31:0]  e_aa;
        logic [7:0]   e_len;
    } vec_t;

    vec_t vecs[8];

    initial begin : main
        int ra, wa, wb;
        logic [2:0] types[4];
        logic [2:0] rt, wt;
        logic [31:0] r_a, w_a;
        logic [127:0] ln;

        vecs[0] = '{1'b0, 3'd4, 32'h1C00_0034, 4'h0, 128'h0, 0, 32'h1C00_0030, 8'd3};
        vecs[1] = '{1'b0, 3'd0, 32'h1234_5677, 4'h0, 128'h0, 0, 32'h1234_5677, 8'd0};
        vecs[2] = '{1'b0, 3'd1, 32'hABCD_0012, 4'h0, 128'h0, 0, 32'hABCD_0012, 8'd0};
        vecs[3] = '{1'b0, 3'd2, 32'h0000_0FFC, 4'h0, 128'h0, 0, 32'h0000_0FFC, 8'd0};
        vecs[4] = '{1'b1, 3'd2, 32'h8000_0008, 4'b0110,
                    128'hCAFE0000_12345678_9ABCDEF0_DEADBEEF, 0, 32'h8000_0008, 8'd0};
        vecs[5] = '{1'b1, 3'd4, 32'h0000_1238, 4'h0,
                    128'h33333333_22222222_11111111_00000000, 1, 32'h0000_1230, 8'd3};
        vecs[6] = '{1'b1, 3'd4, 32'hFFFF_FFFF, 4'h3,
                    128'h0BADF00D_FEEDFACE_01234567_89ABCDEF, 2, 32'hFFFF_FFF0, 8'd3};
        vecs[7] = '{1'b1, 3'd0, 32'h0000_0003, 4'h1,
                    128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_000000A5, 1, 32'h0000_0003, 8'd0};
        types[0] = 3'd0; types[1] = 3'd1; types[2] = 3'd2; types[3] = 3'd4;

        // Reset: all handshakes low even with AXI inputs active.
        rvalid = 1'b1; rlast = 1'b1; wready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_awvalid", awvalid, 1'b0);
        chk1("rst_wvalid", wvalid, 1'b0);
        chk1("rst_rready", rready, 1'b0);
        chk1("rst_bready", bready, 1'b0);
        chk1("rst_ret_valid", ret_valid, 1'b0);
        chk1("rst_ret_last", ret_last, 1'b0);
        @(negedge clk);
        resetn = 1'b1; rvalid = 1'b0; rlast = 1'b0; wready = 1'b0;
        @(negedge clk);
        #1;
        chk1("post_rst_rd_rdy", rd_rdy, 1'b1);
        chk1("post_rst_wr_rdy", wr_rdy, 1'b1);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].t, vecs[i].addr, vecs[i].strb, vecs[i].line, vecs[i].e_aa,
                         vecs[i].e_len, $urandom_range(2, 0), vecs[i].wmode, $urandom_range(2, 0),
                         wa, wb);
            else
                do_read(vecs[i].t, vecs[i].addr, vecs[i].e_aa, vecs[i].e_len,
                        $urandom_range(2, 0), 2, ra);
        end

        // Concurrent line read and line write: accepted in the same cycle.
        fork
            do_read(3'd4, 32'h0000_0100, 32'h0000_0100, 8'd3, 1, 1, ra);
            do_write(3'd4, 32'h0000_0200, 4'h0, 128'h44444444_55555555_66666666_77777777,
                     32'h0000_0200, 8'd3, 2, 0, 1, wa, wb);
        join
        chk32("same_cycle_accept", 32'(ra), 32'(wa));

        // Read of a line with a write in flight.
        fork
            do_write(3'd2, 32'h0000_0040, 4'hf, 128'h0000_0000_0000_0000_0000_0000_1111_2222,
                     32'h0000_0040, 8'd0, 3, 0, 3, wa, wb);
            begin
                @(negedge clk);
                do_read(3'd2, 32'h0000_0044, 32'h0000_0044, 8'd0, 0, 1, ra);
            end
        join
`ifdef BRIDGE_RAW_CHECK_EN
        chk1("raw_read_held", ra > wb, 1'b1);
`else
        chk32("raw_read_immediate", 32'(ra), 32'(wa + 1));
`endif

        // Reset in the middle of a line read.
        @(negedge clk);
        rd_req = 1'b1; rd_type = 3'd4; rd_addr = 32'h0000_0300;
        #1;
        chk1("mid_rst_rd_rdy", rd_rdy, 1'b1);
        @(negedge clk);
        rd_req = 1'b0; rd_type = '0; rd_addr = '0; arready = 1'b1;
        #1;
        chk1("mid_rst_arvalid", arvalid, 1'b1);
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h1234_0000; rlast = 1'b0;
        #1;
        chk1("mid_rst_beat", ret_valid, 1'b1);
        @(negedge clk);
        resetn = 1'b0; rlast = 1'b1;
        #1;
        chk1("in_rst_arvalid", arvalid, 1'b0);
        chk1("in_rst_rready", rready, 1'b0);
        chk1("in_rst_ret_valid", ret_valid, 1'b0);
        chk1("in_rst_ret_last", ret_last, 1'b0);
        @(negedge clk);
        resetn = 1'b1; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
        #1;
        chk1("rel_rd_rdy", rd_rdy, 1'b1);
        chk1("rel_rready", rready, 1'b0);
        chk1("rel_arvalid", arvalid, 1'b0);
        do_read(3'd2, 32'h0000_0308, 32'h0000_0308, 8'd0, 0, 1, ra);

        // Randomized traffic against the model.
        for (int i = 0; i < 24; i++) begin
            rt  = types[$urandom_range(3, 0)];
            wt  = types[$urandom_range(3, 0)];
            r_a = $urandom;
            w_a = $urandom;
            if (w_a[31:4] == r_a[31:4]) w_a = w_a ^ 32'h100;
            ln  = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(2, 0))
                0: do_read(rt, r_a, m_addr(rt, r_a), m_len(rt), $urandom_range(2, 0), 2, ra);
                1: do_write(wt, w_a, 4'($urandom), ln, m_addr(wt, w_a), m_len(wt),
                            $urandom_range(2, 0), 2, $urandom_range(2, 0), wa, wb);
                default: fork
                    do_read(rt, r_a, m_addr(rt, r_a), m_len(rt), $urandom_range(2, 0), 2, ra);
                    do_write(wt, w_a, 4'($urandom), ln, m_addr(wt, w_a), m_len(wt),
                             $urandom_range(2, 0), 2, $urandom_range(2, 0), wa, wb);
                join
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
